// File: rtl/jalr_update_scheduler_pkg.sv
// rtl/jalr_update_scheduler_pkg.sv - shared fetch-side JALR predictor types, sizes and index function
//
// Purpose: common definitions used by the JALR update scheduler and the
// fetch-stage JALR target table lookup path.
// Contents:
//   JALR_PRED_ENTRIES  predictor table entries
//   JALR_ADDR_WIDTH    PC / target width
//   JALR_INDEX_BITS    table index width
//   JALR_UPD_PORTS     number of resolve ports feeding updates
//   jalr_upd_t         one queued table write (index + target)
//   jalr_upd_idx()     table index of a JALR from its link PC
package jalr_update_scheduler_pkg;

    localparam int JALR_PRED_ENTRIES = 16;
    localparam int JALR_ADDR_WIDTH   = 32;
    localparam int JALR_INDEX_BITS   = $clog2(JALR_PRED_ENTRIES);
    localparam int JALR_UPD_PORTS    = 3;

    typedef struct packed {
        logic [JALR_INDEX_BITS-1:0] idx;
        logic [JALR_ADDR_WIDTH-1:0] target;
    } jalr_upd_t;

    // The link PC is instruction PC + 4; index by the word address of the
    // JALR itself so lookup (which sees the instruction PC) and update agree.
    function automatic logic [JALR_INDEX_BITS-1:0] jalr_upd_idx(
        input logic [JALR_ADDR_WIDTH-1:0] pc
    );
        logic [JALR_ADDR_WIDTH-1:0] adj;
        adj = pc - JALR_ADDR_WIDTH'(4);
        return adj[JALR_INDEX_BITS+1:2];
    endfunction

endpackage

// File: rtl/jalr_update_scheduler_fifo.sv
// rtl/jalr_update_scheduler_fifo.sv - multi-push single-pop update FIFO with count and flush
//
// Module jalr_upd_fifo.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           empty the FIFO at the next edge; same-cycle push/pop ignored
//   push_en_i[j]      push slot j this cycle (slot 0 is oldest)
//   push_data_i[j]    data for slot j
//   pop_i             remove the head entry (only asserted when count_o != 0)
//   head_o            head entry, zero when empty
//   count_o           occupancy 0..DEPTH
module jalr_upd_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 8,
    parameter int NPUSH = 3,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [NPUSH-1:0]          push_en_i,
    input  logic [NPUSH-1:0][W-1:0]   push_data_i,
    input  logic                      pop_i,
    output logic [W-1:0]              head_o,
    output logic [CW-1:0]             count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [NPUSH-1:0] push_ok;
    logic [PW-1:0]    wptr [NPUSH];
    logic [CW-1:0]    push_n;

    assign push_ok = flush_i ? '0 : push_en_i;

    // Enabled slots may be sparse; compact them so they land in consecutive
    // locations starting at the tail, preserving slot order.
    always_comb begin
        push_n = '0;
        for (int j = 0; j < NPUSH; j++) begin
            wptr[j] = tail_q + push_n[PW-1:0];
            push_n  = push_n + CW'(push_ok[j]);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_i);
            tail_d  = tail_q + push_n[PW-1:0];
            count_d = count_q + push_n - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NPUSH; j++) begin
            if (push_ok[j]) begin
                mem_q[wptr[j]] <= push_data_i[j];
            end
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[head_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/jalr_update_scheduler.sv
// rtl/jalr_update_scheduler.sv - serialises JALR target-table training writes onto one write port
//
// Purpose: collect up to three mispredicted-JALR updates per cycle, queue them
// oldest-first (port 2, 1, 0) and drain one table write per cycle.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   update_pc_i_k / correct_pc_i_k    link PC and resolved target, port k
//   update_valid_i_k, misprediction_i_k  port k carries a mispredicted JALR
//   flush_i                           discard queued and same-cycle updates
//   wr_valid_o, wr_idx_o, wr_target_o, wr_ready_i  table write handshake
//   count_o                           FIFO occupancy
//   drop_o                            updates lost this cycle (combinational)
//   drop_count_o                      saturating lost-update count
module jalr_update_scheduler
    import jalr_update_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = JALR_ADDR_WIDTH,
    parameter int ENTRIES    = JALR_PRED_ENTRIES,
    parameter int DEPTH      = 8,
    localparam int INDEX_BITS = $clog2(ENTRIES),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] update_pc_i_0,
    input  logic [ADDR_WIDTH-1:0] update_pc_i_1,
    input  logic [ADDR_WIDTH-1:0] update_pc_i_2,
    input  logic                  update_valid_i_0,
    input  logic                  update_valid_i_1,
    input  logic                  update_valid_i_2,
    input  logic                  misprediction_i_0,
    input  logic                  misprediction_i_1,
    input  logic                  misprediction_i_2,
    input  logic [ADDR_WIDTH-1:0] correct_pc_i_0,
    input  logic [ADDR_WIDTH-1:0] correct_pc_i_1,
    input  logic [ADDR_WIDTH-1:0] correct_pc_i_2,
    input  logic                  flush_i,
    output logic                  wr_valid_o,
    output logic [INDEX_BITS-1:0] wr_idx_o,
    output logic [ADDR_WIDTH-1:0] wr_target_o,
    input  logic                  wr_ready_i,
    output logic [CW-1:0]         count_o,
    output logic                  drop_o,
    output logic [15:0]           drop_count_o
);

    localparam int NP = JALR_UPD_PORTS;
    localparam int UW = INDEX_BITS + ADDR_WIDTH;

    // Same rule as jalr_upd_idx(), kept width-generic for non-default parameters.
    function automatic logic [INDEX_BITS-1:0] calc_idx(input logic [ADDR_WIDTH-1:0] pc);
        logic [ADDR_WIDTH-1:0] adj;
        adj = pc - ADDR_WIDTH'(4);
        return adj[INDEX_BITS+1:2];
    endfunction

    // Slot 0 is port 2 (oldest), slot 2 is port 0 (youngest, written last).
    logic [NP-1:0]                 req;
    logic [NP-1:0][ADDR_WIDTH-1:0] pc_s;
    logic [NP-1:0][ADDR_WIDTH-1:0] tgt_s;
    logic [NP-1:0][UW-1:0]         push_data;
    logic [NP-1:0]                 accept;

    assign req[0]   = update_valid_i_2 & misprediction_i_2;
    assign req[1]   = update_valid_i_1 & misprediction_i_1;
    assign req[2]   = update_valid_i_0 & misprediction_i_0;
    assign pc_s[0]  = update_pc_i_2;
    assign pc_s[1]  = update_pc_i_1;
    assign pc_s[2]  = update_pc_i_0;
    assign tgt_s[0] = correct_pc_i_2;
    assign tgt_s[1] = correct_pc_i_1;
    assign tgt_s[2] = correct_pc_i_0;

    always_comb begin
        for (int j = 0; j < NP; j++) begin
            push_data[j] = {calc_idx(pc_s[j]), tgt_s[j]};
        end
    end

    logic [UW-1:0] head;
    logic [CW-1:0] count;
    logic          pop;
    logic [CW-1:0] space;
    logic [CW-1:0] avail;
    logic [1:0]    drop_n;

    assign pop   = (count != '0) & wr_ready_i & ~flush_i;
    // A same-cycle pop frees its slot for the pushes.
    assign space = CW'(DEPTH) - count + CW'(pop);

    always_comb begin
        accept = '0;
        drop_n = '0;
        avail  = space;
        if (!flush_i) begin
            for (int j = 0; j < NP; j++) begin
                if (req[j]) begin
                    if (avail != '0) begin
                        accept[j] = 1'b1;
                        avail     = avail - CW'(1);
                    end else begin
                        drop_n = drop_n + 2'd1;
                    end
                end
            end
        end
    end

    jalr_upd_fifo #(
        .W     (UW),
        .DEPTH (DEPTH),
        .NPUSH (NP)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (flush_i),
        .push_en_i   (accept),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    assign drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_n);
    assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wr_valid_o   = (count != '0);
    assign wr_idx_o     = head[UW-1:ADDR_WIDTH];
    assign wr_target_o  = head[ADDR_WIDTH-1:0];
    assign count_o      = count;
    assign drop_o       = (drop_n != 2'd0);
    assign drop_count_o = drop_cnt_q;

endmodule

// File: doc/jalr_update_scheduler.md
# jalr_update_scheduler

Serialises JALR target-table training writes. Collects up to three misprediction updates per cycle from the commit/resolve ports, buffers them in order in a small FIFO, and drains one write per cycle to the JALR predictor's single table write port under a valid/ready handshake. Sits between the branch-resolution ports and the fetch-stage JALR target table, so the table needs only one write port.

## Interface
- ADDR_WIDTH, 32, PC/target width
- ENTRIES, 16, predictor table entries; INDEX_BITS = $clog2(ENTRIES)
- DEPTH, 8, update FIFO depth (power of two, ≥4)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- update_pc_i_0/1/2  in  ADDR_WIDTH  link PC of resolved JALR (instruction PC + 4)
- update_valid_i_0/1/2  in  1  port carries a resolved JALR
- misprediction_i_0/1/2  in  1  target was mispredicted
- correct_pc_i_0/1/2  in  ADDR_WIDTH  resolved target
- flush_i  in  1  discard all queued updates
- wr_valid_o  out  1  table write pending
- wr_idx_o  out  INDEX_BITS  table index
- wr_target_o  out  ADDR_WIDTH  target to write
- wr_ready_i  in  1  table accepts write this cycle
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_o  out  1  one or more updates lost this cycle
- drop_count_o  out  16  saturating count of lost updates

## Operation
- Request on port k: req_k = update_valid_i_k & misprediction_i_k.
- Index: idx_k = ((update_pc_i_k − 4) >> 2) truncated to INDEX_BITS, i.e. bits [INDEX_BITS+1:2] of (pc − 4).
- Enqueue order in one cycle: port 2, then 1, then 0, so port 0 is the youngest and its write reaches the table last. This matches the last-writer-wins rule when several ports hit the same index.
- Pop: wr_valid_o & wr_ready_i removes the head.
- Space available this cycle: DEPTH − count + pop. A pop frees its slot for the same-cycle push.
- Requests are accepted in enqueue order until space runs out. Remaining requests are dropped; they are never stalled.
- On any drop, drop_o = 1 and drop_count_o increases by the number dropped, saturating at 0xFFFF.
- Outputs come from FIFO storage at the head pointer:
  - wr_valid_o = (count ≠ 0).
  - wr_idx_o and wr_target_o hold the head entry, and are 0 when the FIFO is empty.
- Head contents stay stable while wr_valid_o & !wr_ready_i.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.
- No coalescing: duplicate indices are written in sequence.
- flush_i:
  - Clears head, tail and count next cycle.
  - Same-cycle requests are discarded and are not counted as drops.
  - Same-cycle pop handshake is ignored.
  - drop_count_o is not cleared.

## Timing
- Reset values: wr_valid_o 0, wr_idx_o 0, wr_target_o 0, count_o 0, drop_o 0, drop_count_o 0; pointers 0.
- Reset asserted mid-operation empties the FIFO immediately and asynchronously; queued updates are lost.
- Latency: a request accepted in cycle N appears at the head (if the FIFO was empty) with wr_valid_o = 1 in cycle N+1.
- Throughput: one table write per cycle, sustained.
- Three requests into an empty FIFO with wr_ready_i held high drain in cycles N+1, N+2, N+3.
- drop_o is combinational in the request cycle. drop_count_o updates at the next edge.
- Full FIFO with a pop and three requests: exactly one is accepted, from port 2; ports 1 and 0 are dropped.
- count_o is registered.

## Structure
- Shared fetch package holds:
  - jalr_upd_t struct: idx [INDEX_BITS-1:0], target [ADDR_WIDTH-1:0].
  - JALR_PRED_ENTRIES constant.
  - Index function jalr_upd_idx(pc) = (pc − 4) >> 2, truncated; the predictor lookup path uses the same function.
- One sub-module, jalr_upd_fifo: multi-push (up to 3), single-pop FIFO with count and flush.
- Top level contains request decode, index compute, space/accept logic and the drop counter.

## Test plan
- Reset, then single request: port 1 pc 0x0000_0108, target 0x0000_2000, wr_ready_i = 1 → next cycle wr_valid_o = 1, wr_idx_o = 1, wr_target_o = 0x2000; the cycle after, wr_valid_o = 0.
- Three ports same cycle:
  - Stimulus: p2 pc 0x14 target 0xA0; p1 pc 0x24 target 0xB0; p0 pc 0x14 target 0xC0.
  - Required: writes appear in order (idx 4, 0xA0), (idx 8, 0xB0), (idx 4, 0xC0).
- Backpressure: wr_ready_i = 0 for 5 cycles with one entry queued → head stable, count_o = 1; raising wr_ready_i completes the pop in that cycle.
- Overflow:
  - Stimulus: fill to DEPTH = 8 with wr_ready_i = 0, then 3 requests.
  - Required: drop_o = 1, drop_count_o = 3, count_o stays 8.
  - Repeat with wr_ready_i = 1: port 2 accepted, drop_count_o = 5.
- Misprediction gating: update_valid_i = 1 with misprediction_i = 0 on all ports → count_o stays 0.
- Flush and reset: queue 5 entries, flush_i together with 2 new requests → count_o = 0 next cycle, no drops; then assert reset mid-drain → all outputs 0 immediately.
